bsram_readback: RTL and testbench

- Read-back verifier for the program BSRAM, the reader counterpart of the boot-time image writer.
- After boot has written the program image into the single-port BSRAM, this block takes the memory port, streams out words 0..DEPTH-1, and compares each against the expected boot image.
- Reports pass/fail, the error count and the first mismatch, so the top level can hold the CPU in reset or flag the fault on the LEDs.
- Sits beside the boot sequencer on the BSRAM address mux; it owns the port only while mem_req is high.

---
 rtl/bsram_readback_if.sv | 31 +++
 rtl/bsram_readback.sv | 181 ++++++++++++++++++
 tb/tb_bsram_readback.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsram_readback_if.sv
// BSRAM read port plus boot-image table lookup, shared between the
// read-back verifier (master) and the memory/table side (slave).
interface bsram_readback_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_ce;
    logic [ADDR_W-1:0] mem_ad;
    logic [DATA_W-1:0] mem_dout;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

    modport master (
        output mem_req,
        output mem_ce,
        output mem_ad,
        output exp_addr,
        input  mem_dout,
        input  exp_data
    );

    modport slave (
        input  mem_req,
        input  mem_ce,
        input  mem_ad,
        input  exp_addr,
        output mem_dout,
        output exp_data
    );
endinterface

// File: rtl/bsram_readback.sv
// Reads back BSRAM words 0..DEPTH-1 after boot and compares each against the
// boot image table, reporting pass/fail, error count and the first mismatch.
module bsram_readback #(
    parameter  int ADDR_W   = 11,
    parameter  int DATA_W   = 16,
    parameter  int DEPTH    = 16,
    parameter  int READ_LAT = 1,
    localparam int ERR_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    bsram_readback_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [1:0]        dbg_state
);
    // Handshake: start is a one-cycle pulse, accepted only in IDLE or DONE;
    // a pulse while busy is dropped and the running pass is unaffected.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(READ_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic              start_acc;
    logic [ADDR_W-1:0] issue_cnt;
    logic [1:0]        drain_cnt;
    logic              mem_req_c;
    logic [ADDR_W-1:0] mem_ad_c;

    logic              tag_v [READ_LAT];
    logic [ADDR_W-1:0] tag_a [READ_LAT];
    logic              tag_v_out;
    logic [ADDR_W-1:0] tag_a_out;
    logic [ADDR_W-1:0] exp_addr_q;
    logic [ADDR_W-1:0] exp_addr_c;
    logic              mismatch;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_cnt == LAST_ADDR) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem_req_c = 1'b0;
        mem_ad_c  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_ISSUE: begin
                mem_req_c = 1'b1;
                mem_ad_c  = issue_cnt;
                busy      = 1'b1;
            end
            S_DRAIN: begin
                mem_req_c = 1'b1;
                busy      = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                mem_req_c = 1'b0;
            end
        endcase
    end

    assign bus.mem_req = mem_req_c;
    assign bus.mem_ce  = mem_req_c;
    assign bus.mem_ad  = mem_ad_c;
    assign dbg_state   = state;
    assign pass        = done && (err_count == '0);

    // Issue counter parks on the last address so it never wraps at full depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            if (start_acc) begin
                issue_cnt <= '0;
            end else if (state == S_ISSUE && issue_cnt != LAST_ADDR) begin
                issue_cnt <= issue_cnt + ADDR_W'(1);
            end
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        end
    end

    // Tag pipeline mirrors the BSRAM read latency so each returning word
    // arrives with the address it was read from.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                tag_v[i] <= 1'b0;
                tag_a[i] <= '0;
            end
        end else begin
            tag_v[0] <= (state == S_ISSUE);
            tag_a[0] <= issue_cnt;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_a[i] <= tag_a[i-1];
            end
        end
    end

    assign tag_v_out  = tag_v[READ_LAT-1];
    assign tag_a_out  = tag_a[READ_LAT-1];
    assign exp_addr_c = tag_v_out ? tag_a_out : exp_addr_q;
    assign bus.exp_addr = exp_addr_c;
    assign mismatch   = tag_v_out && (bus.mem_dout != bus.exp_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_addr_q <= '0;
        end else begin
            exp_addr_q <= exp_addr_c;
        end
    end

    // Result registers; first_err_* is only written by the first mismatch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (start_acc) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (mismatch) begin
            err_count <= err_count + ERR_W'(1);
            if (err_count == '0) begin
                first_err_addr <= tag_a_out;
                first_err_data <= bus.mem_dout;
            end
        end
    end
endmodule

// File: tb/tb_bsram_readback.sv
// Bench for bsram_readback: one instance with READ_LAT=1 and one with
// READ_LAT=2, each backed by a behavioural BSRAM and boot-image table.
module tb_bsram_readback;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int EW = 5;

    logic clk;
    logic rst;
    logic start_a;
    logic start_b;

    bsram_readback_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    bsram_readback_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    logic          busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [EW-1:0] errc_a, errc_b;
    logic [AW-1:0] fa_a, fa_b;
    logic [DW-1:0] fd_a, fd_b;
    logic [1:0]    st_a, st_b;

    bsram_readback #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(16), .READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(bus_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(errc_a),
        .first_err_addr(fa_a), .first_err_data(fd_a), .dbg_state(st_a)
    );

    bsram_readback #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(16), .READ_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(bus_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(errc_b),
        .first_err_addr(fa_b), .first_err_data(fd_b), .dbg_state(st_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory and image models ----------------
    logic [DW-1:0] img   [16];
    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];
    logic [DW-1:0] rd_a, rd_b1, rd_b2;

    always @(posedge clk) begin
        if (bus_a.mem_ce) rd_a <= mem_a[bus_a.mem_ad[3:0]];
        if (bus_b.mem_ce) rd_b1 <= mem_b[bus_b.mem_ad[3:0]];
        rd_b2 <= rd_b1;
    end

    assign bus_a.mem_dout = rd_a;
    assign bus_b.mem_dout = rd_b2;
    assign bus_a.exp_data = img[bus_a.exp_addr[3:0]];
    assign bus_b.exp_data = img[bus_b.exp_addr[3:0]];

    // ---------------- view of the instance under test ----------------
    bit            sel;
    logic          v_req, v_ce, v_busy, v_done, v_pass;
    logic [AW-1:0] v_ad, v_ea, v_fa;
    logic [DW-1:0] v_fd;
    logic [EW-1:0] v_errc;

    always_comb begin
        v_req  = sel ? bus_b.mem_req  : bus_a.mem_req;
        v_ce   = sel ? bus_b.mem_ce   : bus_a.mem_ce;
        v_ad   = sel ? bus_b.mem_ad   : bus_a.mem_ad;
        v_ea   = sel ? bus_b.exp_addr : bus_a.exp_addr;
        v_busy = sel ? busy_b : busy_a;
        v_done = sel ? done_b : done_a;
        v_pass = sel ? pass_b : pass_a;
        v_errc = sel ? errc_b : errc_a;
        v_fa   = sel ? fa_b : fa_a;
        v_fd   = sel ? fd_b : fd_a;
    end

    // ---------------- scoreboard ----------------
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] ea_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic load_images();
        for (int i = 0; i < 16; i++) begin
            img[i] = (i == 5) ? 16'h0000 : DW'(16'h3C00 + i * 16'h0111);
            mem_a[i] = img[i];
            mem_b[i] = img[i];
        end
    endtask

    task automatic pulse_start(input bit s);
        if (s) start_b = 1'b1;
        else   start_a = 1'b1;
    endtask

    // Runs one full pass on the selected instance, checking the issue stream,
    // compare addresses, port ownership and the final results cycle by cycle.
    task automatic run_pass(input bit s, input int lat, input int mid_start,
                            input int exp_err, input logic [AW-1:0] fa,
                            input logic [DW-1:0] fd);
        int done_cyc;
        logic [AW-1:0] e;
        done_cyc = 17 + lat;
        sel = s;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(AW'(k));
            ea_q.push_back(AW'(k));
        end
        @(posedge clk); #1;
        pulse_start(s);
        for (int c = 1; c <= done_cyc; c++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            start_b = 1'b0;
            if (c == mid_start) pulse_start(s);
            if (c == 1) begin
                n_vec++;
                if (v_done !== 1'b0) begin n_err++; $display("FAIL done_cleared: got %0h want 0", v_done); end
                n_vec++;
                if (v_errc !== '0) begin n_err++; $display("FAIL errc_cleared: got %0h want 0", v_errc); end
            end
            if (c <= 16) begin
                e = exp_q.pop_front();
                n_vec++;
                if (v_ad !== e) begin n_err++; $display("FAIL mem_ad c%0d: got %0h want %0h", c, v_ad, e); end
            end
            n_vec++;
            if (v_req !== (c <= 16 + lat)) begin
                n_err++; $display("FAIL mem_req c%0d: got %0h want %0h", c, v_req, (c <= 16 + lat));
            end
            n_vec++;
            if (v_ce !== (c <= 16 + lat)) begin
                n_err++; $display("FAIL mem_ce c%0d: got %0h want %0h", c, v_ce, (c <= 16 + lat));
            end
            if (c >= lat + 1 && c <= lat + 16) begin
                e = ea_q.pop_front();
                n_vec++;
                if (v_ea !== e) begin n_err++; $display("FAIL exp_addr c%0d: got %0h want %0h", c, v_ea, e); end
            end
            if (c == done_cyc - 1) begin
                n_vec++;
                if (v_done !== 1'b0) begin n_err++; $display("FAIL done_early: got %0h want 0", v_done); end
            end
        end
        n_vec++;
        if (v_done !== 1'b1) begin n_err++; $display("FAIL done_rise: got %0h want 1", v_done); end
        n_vec++;
        if (v_busy !== 1'b0) begin n_err++; $display("FAIL busy_end: got %0h want 0", v_busy); end
        n_vec++;
        if (v_pass !== (exp_err == 0)) begin n_err++; $display("FAIL pass: got %0h want %0h", v_pass, (exp_err == 0)); end
        n_vec++;
        if (v_errc !== EW'(exp_err)) begin n_err++; $display("FAIL err_count: got %0d want %0d", v_errc, exp_err); end
        if (exp_err > 0) begin
            n_vec++;
            if (v_fa !== fa) begin n_err++; $display("FAIL first_err_addr: got %0h want %0h", v_fa, fa); end
            n_vec++;
            if (v_fd !== fd) begin n_err++; $display("FAIL first_err_data: got %0h want %0h", v_fd, fd); end
        end
        @(posedge clk); #1;
        n_vec++;
        if (v_done !== 1'b1) begin n_err++; $display("FAIL done_sticky: got %0h want 1", v_done); end
        n_vec++;
        if (exp_q.size() != 0 || ea_q.size() != 0) begin
            n_err++; $display("FAIL queue_drain: got %0d want 0", exp_q.size() + ea_q.size());
        end
        exp_q.delete();
        ea_q.delete();
    endtask

    task automatic check_all_zero(input bit s, input string tag);
        sel = s;
        #0;
        n_vec++;
        if ({v_req, v_ce, v_busy, v_done, v_pass} !== 5'b0) begin
            n_err++; $display("FAIL %s_flags: got %0h want 0", tag, {v_req, v_ce, v_busy, v_done, v_pass});
        end
        n_vec++;
        if ({v_ad, v_ea} !== '0) begin n_err++; $display("FAIL %s_addr: got %0h want 0", tag, {v_ad, v_ea}); end
        n_vec++;
        if ({v_errc, v_fa, v_fd} !== '0) begin
            n_err++; $display("FAIL %s_results: got %0h want 0", tag, {v_errc, v_fa, v_fd});
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero(0, "reset_a");
        check_all_zero(1, "reset_b");
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero(0, "idle_a");
        check_all_zero(1, "idle_b");
    endtask

    task automatic test_match();
        load_images();
        run_pass(0, 1, 0, 0, '0, '0);
    endtask

    task automatic test_single_error();
        load_images();
        mem_a[5] = 16'h00A2;
        run_pass(0, 1, 0, 1, AW'(5), 16'h00A2);
    endtask

    task automatic test_two_errors();
        load_images();
        mem_a[3] = img[3] ^ 16'h5A5A;
        mem_a[9] = ~img[9];
        run_pass(0, 1, 0, 2, AW'(3), img[3] ^ 16'h5A5A);
    endtask

    task automatic test_mid_start_and_rerun();
        load_images();
        mem_a[5] = 16'h00A2;
        run_pass(0, 1, 6, 1, AW'(5), 16'h00A2);
        load_images();
        run_pass(0, 1, 0, 0, '0, '0);
    endtask

    task automatic test_reset_mid_pass();
        load_images();
        mem_a[3] = 16'hBEEF;
        sel = 0;
        @(posedge clk); #1;
        start_a = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
        end
        n_vec++;
        if (errc_a !== EW'(1)) begin n_err++; $display("FAIL pre_reset_errc: got %0d want 1", errc_a); end
        n_vec++;
        if (bus_a.mem_req !== 1'b1) begin n_err++; $display("FAIL pre_reset_req: got %0h want 1", bus_a.mem_req); end
        rst = 1'b0;
        #1;
        check_all_zero(0, "async_reset");
        @(posedge clk); #1;
        check_all_zero(0, "held_reset");
        rst = 1'b1;
        load_images();
        run_pass(0, 1, 0, 0, '0, '0);
    endtask

    task automatic test_lat2();
        load_images();
        run_pass(1, 2, 0, 0, '0, '0);
        mem_b[15] = 16'h1234;
        run_pass(1, 2, 0, 1, AW'(15), 16'h1234);
    endtask

    initial begin
        sel = 0;
        test_reset();
        test_match();
        test_single_error();
        test_two_errors();
        test_mid_start_and_rerun();
        test_reset_mid_pass();
        test_lat2();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
